instr_fetch_unit: RTL and testbench

Multi-cycle instruction fetch and next-PC sequencer for the RV32I core. It owns the program counter, reads instruction words from instruction memory over a req/ack handshake, and presents each word to the control unit and register file with a valid/ready handshake. It consumes the branch decision signals (Branch, BranchSelect, ZFlag, SignFlag, target) computed for the issued word and selects the next PC. It sits between instruction memory and the control unit.

---
 rtl/rv_core_pkg.sv | 23 ++
 rtl/instr_fetch_unit_branch_resolve.sv | 34 +++
 rtl/instr_fetch_unit.sv | 120 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_core_pkg.sv
// Shared RV32I core definitions: fetch FSM states, BranchSelect encodings,
// fetch error codes and the default reset PC.
package rv_core_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFetch = 2'd1,
        StIssue = 2'd2,
        StError = 2'd3
    } fetch_state_t;

    localparam logic [1:0] BR_EQ = 2'd0;
    localparam logic [1:0] BR_NE = 2'd1;
    localparam logic [1:0] BR_LT = 2'd2;
    localparam logic [1:0] BR_GE = 2'd3;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd1;
    localparam logic [1:0] ERR_MISALIGN = 2'd2;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/instr_fetch_unit_branch_resolve.sv
// Combinational branch decision and next-PC selection for the issued word.
module branch_resolve
    import rv_core_pkg::*;
(
    input  logic [31:0] i_pc,
    input  logic        i_branch,
    input  logic [1:0]  i_sel,
    input  logic        i_zflag,
    input  logic        i_sflag,
    input  logic [31:0] i_target,
    output logic        o_taken,
    output logic [31:0] o_next_pc,
    output logic        o_misaligned
);

    logic w_cond;

    always_comb begin
        w_cond = 1'b0;
        case (i_sel)
            BR_EQ:   w_cond = i_zflag;
            BR_NE:   w_cond = ~i_zflag;
            BR_LT:   w_cond = ~i_zflag;  // slt result is nonzero
            BR_GE:   w_cond = ~i_sflag;
            default: w_cond = 1'b0;
        endcase
    end

    assign o_taken      = i_branch & w_cond;
    assign o_next_pc    = o_taken ? i_target : i_pc + 32'd4;
    // Raw alignment of the target; only meaningful when o_taken is set.
    assign o_misaligned = |i_target[1:0];

endmodule

// File: rtl/instr_fetch_unit.sv
// Multi-cycle instruction fetch: owns the PC, fetches over req/ack, issues
// words over valid/ready and picks the next PC from the branch decision.
module instr_fetch_unit
    import rv_core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        ir_valid,
    input  logic        ir_ready,
    output logic [31:0] ir_word,
    output logic [31:0] ir_pc,
    input  logic        br_branch,
    input  logic [1:0]  br_sel,
    input  logic        br_zflag,
    input  logic        br_sflag,
    input  logic [31:0] br_target,
    output logic [31:0] retired,
    output logic [1:0]  fetch_err
);

    fetch_state_t r_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_ir_word;
    logic [31:0]  r_ir_pc;
    logic [31:0]  r_wdog;
    logic [31:0]  r_retired;
    logic [1:0]   r_fetch_err;
    logic         r_imem_req;
    logic         r_ir_valid;

    logic         w_taken;
    logic [31:0]  w_next_pc;
    logic         w_misaligned;

    branch_resolve u_branch_resolve (
        .i_pc         (r_pc),
        .i_branch     (br_branch),
        .i_sel        (br_sel),
        .i_zflag      (br_zflag),
        .i_sflag      (br_sflag),
        .i_target     (br_target),
        .o_taken      (w_taken),
        .o_next_pc    (w_next_pc),
        .o_misaligned (w_misaligned)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= StIdle;
            r_pc        <= RESET_PC;
            r_ir_word   <= '0;
            r_ir_pc     <= '0;
            r_wdog      <= '0;
            r_retired   <= '0;
            r_fetch_err <= ERR_NONE;
            r_imem_req  <= 1'b0;
            r_ir_valid  <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    r_state    <= StFetch;
                    r_wdog     <= '0;
                    r_imem_req <= 1'b1;
                end
                StFetch: begin
                    // Ack takes priority over a watchdog expiring in the same cycle.
                    if (imem_ack) begin
                        r_ir_word  <= imem_rdata;
                        r_ir_pc    <= r_pc;
                        r_state    <= StIssue;
                        r_imem_req <= 1'b0;
                        r_ir_valid <= 1'b1;
                    end else if (TIMEOUT != 0 && r_wdog == TIMEOUT - 1) begin
                        r_state     <= StError;
                        r_fetch_err <= ERR_TIMEOUT;
                        r_imem_req  <= 1'b0;
                    end else begin
                        r_wdog <= r_wdog + 32'd1;
                    end
                end
                StIssue: begin
                    if (ir_ready) begin
                        r_retired  <= r_retired + 32'd1;
                        r_ir_valid <= 1'b0;
                        if (w_taken && w_misaligned) begin
                            r_state     <= StError;
                            r_fetch_err <= ERR_MISALIGN;
                        end else begin
                            r_pc       <= w_next_pc;
                            r_wdog     <= '0;
                            r_state    <= StFetch;
                            r_imem_req <= 1'b1;
                        end
                    end
                end
                StError: begin
                    r_imem_req <= 1'b0;
                    r_ir_valid <= 1'b0;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign imem_req  = r_imem_req;
    assign imem_addr = r_pc;
    assign ir_valid  = r_ir_valid;
    assign ir_word   = r_ir_word;
    assign ir_pc     = r_ir_pc;
    assign retired   = r_retired;
    assign fetch_err = r_fetch_err;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: issued words are scoreboarded against
// the fetched data and the next PC is predicted from the branch rules.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        ir_valid;
    logic        ir_ready;
    logic [31:0] ir_word;
    logic [31:0] ir_pc;
    logic        br_branch;
    logic [1:0]  br_sel;
    logic        br_zflag;
    logic        br_sflag;
    logic [31:0] br_target;
    logic [31:0] retired;
    logic [1:0]  fetch_err;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } issue_t;

    issue_t      sb[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_retired = 0;

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .ir_valid   (ir_valid),
        .ir_ready   (ir_ready),
        .ir_word    (ir_word),
        .ir_pc      (ir_pc),
        .br_branch  (br_branch),
        .br_sel     (br_sel),
        .br_zflag   (br_zflag),
        .br_sflag   (br_sflag),
        .br_target  (br_target),
        .retired    (retired),
        .fetch_err  (fetch_err)
    );

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench did not finish");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_next(input logic [31:0] pc, input logic br,
                                               input logic [1:0] sel, input logic z,
                                               input logic s, input logic [31:0] tgt);
        logic t;
        case (sel)
            2'd0:    t = z;
            2'd1:    t = !z;
            2'd2:    t = !z;
            default: t = !s;
        endcase
        return (br && t) ? tgt : pc + 32'd4;
    endfunction

    // Entered one cycle into FETCH; leaves one cycle after the issue handshake.
    task automatic do_instr(input logic [31:0] pc, input int nwait, input int nstall,
                            input logic br, input logic [1:0] sel, input logic z,
                            input logic s, input logic [31:0] tgt,
                            output logic [31:0] next_pc);
        issue_t e;
        issue_t got;
        chk("fetch_req", {31'd0, imem_req}, 32'd1);
        chk("fetch_addr", imem_addr, pc);
        for (int i = 0; i < nwait; i++) begin
            tick();
            chk("wait_req", {31'd0, imem_req}, 32'd1);
            chk("wait_addr", imem_addr, pc);
        end
        e.pc       = pc;
        e.word     = $urandom;
        imem_ack   = 1'b1;
        imem_rdata = e.word;
        sb.push_back(e);
        tick();
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        got = sb.pop_front();
        chk("issue_valid", {31'd0, ir_valid}, 32'd1);
        chk("issue_noreq", {31'd0, imem_req}, 32'd0);
        chk("issue_word", ir_word, got.word);
        chk("issue_pc", ir_pc, got.pc);
        for (int i = 0; i < nstall; i++) begin
            ir_ready   = 1'b0;
            imem_ack   = 1'b1;
            imem_rdata = $urandom;
            br_branch  = 1'b1;
            br_sel     = 2'($urandom);
            br_zflag   = 1'($urandom);
            br_sflag   = 1'($urandom);
            br_target  = {$urandom} & 32'hFFFF_FFFC;
            tick();
            chk("stall_valid", {31'd0, ir_valid}, 32'd1);
            chk("stall_noreq", {31'd0, imem_req}, 32'd0);
            chk("stall_word", ir_word, got.word);
            chk("stall_pc", ir_pc, got.pc);
        end
        imem_ack  = 1'b0;
        ir_ready  = 1'b1;
        br_branch = br;
        br_sel    = sel;
        br_zflag  = z;
        br_sflag  = s;
        br_target = tgt;
        tick();
        ir_ready  = 1'b0;
        br_branch = 1'($urandom);
        br_target = $urandom;
        exp_retired++;
        chk("retired", retired, exp_retired);
        next_pc = model_next(pc, br, sel, z, s, tgt);
    endtask

    logic [31:0] pc;
    logic [31:0] npc;
    logic [1:0]  t_sel[9] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};
    logic        t_z  [9] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic        t_s  [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic        t_br [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    initial begin
        rst        = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        ir_ready   = 1'b0;
        br_branch  = 1'b0;
        br_sel     = 2'd0;
        br_zflag   = 1'b0;
        br_sflag   = 1'b0;
        br_target  = 32'h0;
        tick();
        tick();
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, ir_valid}, 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_word", ir_word, 32'h0);
        chk("rst_pc", ir_pc, 32'h0);
        chk("rst_retired", retired, 32'h0);
        chk("rst_err", {30'd0, fetch_err}, 32'd0);

        // Zero-wait stream 0, 4, 8 then a slow ack and a stalled decode.
        rst = 1'b1;
        tick();
        pc = 32'h0;
        for (int i = 0; i < 3; i++) begin
            do_instr(pc, 0, 0, 1'b0, 2'd0, 1'b0, 1'b0, 32'h0, npc);
            pc = npc;
        end
        chk("retired_three", retired, 32'd3);
        do_instr(pc, 3, 5, 1'b0, 2'd0, 1'b0, 1'b0, 32'h0, npc);
        pc = npc;
        chk("pc_after_stall", pc, 32'd16);

        // Taken/not-taken across every BranchSelect, plus br_branch=0.
        for (int i = 0; i < 9; i++) begin
            do_instr(pc, 0, 0, t_br[i], t_sel[i], t_z[i], t_s[i],
                     32'h100 * (i + 1), npc);
            pc = npc;
        end

        // Fetch watchdog: 16 FETCH cycles without ack.
        chk("wd_start_addr", imem_addr, pc);
        for (int i = 0; i < 15; i++) tick();
        chk("wd_last_req", {31'd0, imem_req}, 32'd1);
        chk("wd_last_err", {30'd0, fetch_err}, 32'd0);
        tick();
        chk("wd_err", {30'd0, fetch_err}, 32'd1);
        chk("wd_req", {31'd0, imem_req}, 32'd0);
        chk("wd_valid", {31'd0, ir_valid}, 32'd0);
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        chk("err_hold", {30'd0, fetch_err}, 32'd1);
        chk("err_hold_valid", {31'd0, ir_valid}, 32'd0);

        rst = 1'b0;
        tick();
        chk("rerst_addr", imem_addr, 32'h0);
        chk("rerst_err", {30'd0, fetch_err}, 32'd0);
        chk("rerst_retired", retired, 32'h0);
        chk("rerst_req", {31'd0, imem_req}, 32'd0);
        exp_retired = 0;
        rst = 1'b1;
        tick();

        // Ack in the same cycle the watchdog would expire.
        do_instr(32'h0, 15, 0, 1'b0, 2'd0, 1'b0, 1'b0, 32'h0, npc);
        chk("ack_wins_err", {30'd0, fetch_err}, 32'd0);

        // PC wrap at the top of the address space.
        do_instr(npc, 0, 0, 1'b1, 2'd0, 1'b1, 1'b0, 32'hFFFF_FFFC, npc);
        do_instr(npc, 0, 0, 1'b0, 2'd0, 1'b0, 1'b0, 32'h0, npc);
        chk("wrap_pc", npc, 32'h0);

        // Taken branch to a misaligned target.
        do_instr(npc, 0, 0, 1'b1, 2'd1, 1'b0, 1'b0, 32'h102, npc);
        chk("mis_err", {30'd0, fetch_err}, 32'd2);
        chk("mis_req", {31'd0, imem_req}, 32'd0);
        chk("mis_valid", {31'd0, ir_valid}, 32'd0);
        chk("mis_addr", imem_addr, 32'h0);
        tick();
        chk("mis_hold", {30'd0, fetch_err}, 32'd2);
        chk("mis_retired", retired, exp_retired);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
